// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender: extension modes and skid-buffer states.
// Pure declarations; no logic and no latency of its own.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN  = 2'd0,
        MODE_ZERO  = 2'd1,
        MODE_UPPER = 2'd2,
        MODE_SHAMT = 2'd3
    } imm_mode_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    // MIPS-style shift amount field position inside the immediate
    localparam int SHAMT_LSB = 6;
    localparam int SHAMT_W   = 5;

    localparam int STATS_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: SIGN, ZERO, UPPER (LUI-style) and SHAMT field extraction.
// Zero latency; no handshake, the caller registers the result.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  immediate,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    always_comb begin
        result = '0;
        case (imm_mode_e'(mode))
            MODE_SIGN:  result = {{(OUT_W-IN_W){immediate[IN_W-1]}}, immediate};
            MODE_ZERO:  result = {{(OUT_W-IN_W){1'b0}}, immediate};
            MODE_UPPER: result = {immediate, {(OUT_W-IN_W){1'b0}}};
            MODE_SHAMT: result = {{(OUT_W-SHAMT_W){1'b0}},
                                  immediate[SHAMT_LSB+SHAMT_W-1:SHAMT_LSB]};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender behind a two-entry skid buffer; IMM_EXT_STATS_EN adds neg_count.
// One-cycle latency when empty; in_ready is a flop that drops only when both entries are held.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  immediate,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extendedImmediate
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [STATS_W-1:0] neg_count
`endif
);

    buf_state_e       state_q, state_d;
    logic [OUT_W-1:0] ext_result;
    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] tail_q, tail_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             deliver;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .immediate (immediate),
        .mode      (mode),
        .result    (ext_result)
    );

    assign accept  = in_valid && in_ready_q;
    assign deliver = out_valid_q && out_ready;

    // head is always the entry on the output; tail only holds the younger entry in FULL
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_ONE;
                        head_d  = ext_result;
                    end
                end
                BUF_ONE: begin
                    if (accept && deliver) begin
                        head_d = ext_result;
                    end else if (accept) begin
                        state_d = BUF_FULL;
                        tail_d  = ext_result;
                    end else if (deliver) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (deliver) begin
                        state_d = BUF_ONE;
                        head_d  = tail_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state so they never depend on inputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= BUF_EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            in_ready_q  <= (state_d != BUF_FULL);
            out_valid_q <= (state_d != BUF_EMPTY);
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign extendedImmediate = head_q;

`ifdef IMM_EXT_STATS_EN
    logic [STATS_W-1:0] neg_q;

    // Inputs dropped by a same-cycle flush were never taken, so they are not counted
    always_ff @(posedge clock) begin
        if (reset) begin
            neg_q <= '0;
        end else if (accept && !flush && (mode == MODE_SIGN) && immediate[IN_W-1]) begin
            neg_q <= neg_q + STATS_W'(1);
        end
    end

    assign neg_count = neg_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: expected results queued on accept, compared on delivery.
module tb_imm_extend_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic             clock     = 1'b0;
    logic             reset     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             flush     = 1'b0;
    logic             out_ready = 1'b1;
    logic [IN_W-1:0]  immediate = '0;
    logic [1:0]       mode      = 2'd0;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] extendedImmediate;
`ifdef IMM_EXT_STATS_EN
    logic [15:0]      neg_count;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    always #5 clock = ~clock;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .immediate         (immediate),
        .mode              (mode),
        .flush             (flush),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .extendedImmediate (extendedImmediate)
`ifdef IMM_EXT_STATS_EN
        ,
        .neg_count         (neg_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] m, input logic [15:0] v);
        case (m)
            2'd0:    return {{16{v[15]}}, v};
            2'd1:    return {16'h0000, v};
            2'd2:    return {v, 16'h0000};
            default: return {27'd0, v[10:6]};
        endcase
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [1:0] m, input logic [15:0] v);
        in_valid  = 1'b1;
        mode      = m;
        immediate = v;
    endtask

    // Sampled on the falling edge: what is seen here is what the next rising edge acts on
    always @(negedge clock) begin
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                else
                    chk("sb_data", extendedImmediate, sb_q.pop_front());
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(mode, immediate));
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0]  t_mode[4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [15:0] t_imm[4]  = '{16'h8000, 16'h8000, 16'h1234, 16'h0140};
    logic [31:0] t_exp[4]  = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'h00000005};

    initial begin
        // reset with a pending input that must be ignored
        reset = 1'b1;
        present(2'd0, 16'h8000);
        tick;
        tick;
        @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_data", extendedImmediate, 32'd0);
        tick;
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // each mode, result one cycle after accept
        for (int i = 0; i < 4; i++) begin
            tick;
            present(t_mode[i], t_imm[i]);
            tick;
            in_valid = 1'b0;
            @(negedge clock);
            chk("lat_valid", {31'd0, out_valid}, 32'd1);
            chk("lat_data", extendedImmediate, t_exp[i]);
        end
        tick;

        // backpressure into FULL, extra input ignored, then ordered drain
        out_ready = 1'b0;
        present(2'd0, 16'h0001);
        tick;
        present(2'd0, 16'h0002);
        tick;
        present(2'd0, 16'h00FF);
        @(negedge clock);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            @(negedge clock);
            chk("stall_data", extendedImmediate, 32'h00000001);
        end
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("order_first", extendedImmediate, 32'h00000001);
        tick;
        @(negedge clock);
        chk("order_second", extendedImmediate, 32'h00000002);
        chk("order_in_ready", {31'd0, in_ready}, 32'd1);
        tick;

        // back-to-back ZERO inputs: simultaneous accept and deliver in ONE
        for (int i = 0; i < 8; i++) begin
            present(2'd1, 16'(16'h8000 + i));
            @(negedge clock);
            chk("bb_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                chk("bb_out_valid", {31'd0, out_valid}, 32'd1);
                chk("bb_data", extendedImmediate, model(2'd1, 16'(16'h8000 + i - 1)));
            end
            tick;
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("bb_last", extendedImmediate, 32'h00008007);
        tick;

        // flush in FULL with a same-cycle input
        out_ready = 1'b0;
        present(2'd0, 16'hAAAA);
        tick;
        present(2'd0, 16'h5555);
        tick;
        present(2'd0, 16'h7777);
        flush = 1'b1;
        @(negedge clock);
        chk("fl_pre_in_ready", {31'd0, in_ready}, 32'd0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        tick;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("fl_idle", {31'd0, out_valid}, 32'd0);
            tick;
        end

        // reset while two entries are held
        out_ready = 1'b0;
        present(2'd2, 16'h00AB);
        tick;
        present(2'd2, 16'h00CD);
        tick;
        in_valid = 1'b0;
        reset    = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clock);
        chk("rmid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rmid_data", extendedImmediate, 32'd0);
        tick;
        out_ready = 1'b1;
        @(negedge clock);
        chk("rmid_idle", {31'd0, out_valid}, 32'd0);
        tick;

`ifdef IMM_EXT_STATS_EN
        chk("st_reset", {16'h0, neg_count}, 32'd0);
        present(2'd0, 16'h8001);
        tick;
        present(2'd0, 16'hFFFF);
        tick;
        present(2'd0, 16'h8000);
        tick;
        present(2'd0, 16'h7FFF);
        tick;
        present(2'd1, 16'h8000);
        tick;
        in_valid = 1'b0;
        @(negedge clock);
        chk("st_count", {16'h0, neg_count}, 32'd3);
        tick;
        for (int k = 0; k < 65532; k++) begin
            present(2'd0, 16'hC000);
            tick;
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk("st_max", {16'h0, neg_count}, 32'h0000FFFF);
        tick;
        present(2'd0, 16'h9000);
        tick;
        in_valid = 1'b0;
        @(negedge clock);
        chk("st_wrap", {16'h0, neg_count}, 32'd0);
        tick;
`endif

        // drain whatever is still expected, with a bounded wait
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++)
            tick;
        chk("drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
